// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM encodings and
// the width of the entry/credit counter.
package fetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        DROP = ST_DROP
    } fetch_state_e;

    // One extra bit so a completely full queue (count == DEPTH) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {instruction, address} entries; flush beats push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // Underflow/overflow guards; a push into a full queue is legal only alongside a pop.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: single outstanding memory request feeding a DEPTH-entry queue.
// Optional FETCH_BYPASS_EN presents a response straight to the core when the queue is empty.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic               mem_valid,
    input  logic [INSTR_W-1:0] mem_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_take,
    output logic               fetch_empty
);
    localparam int CW = cnt_width(DEPTH);
    localparam int EW = INSTR_W + ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [CW-1:0]     count, count_nxt;
    logic [EW-1:0]     head;
    logic              head_valid, accept, bypass_hit, fifo_push, fifo_pop;

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(EW), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({mem_data, req_addr_q}),
        .rdata (head),
        .count (count)
    );

    assign head_valid = (count != '0);
    assign accept     = (state_q == WAIT) && mem_valid && !redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = accept && !head_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed response taken in the same cycle never occupies a queue slot.
    assign fifo_push = accept && !(bypass_hit && instr_take);
    assign fifo_pop  = head_valid && instr_take && !redirect;
    assign count_nxt = count + CW'(fifo_push) - CW'(fifo_pop);

    assign instr_valid = head_valid || bypass_hit;
    assign instr_data  = bypass_hit ? mem_data   : (head_valid ? head[EW-1:ADDR_W] : '0);
    assign instr_pc    = bypass_hit ? req_addr_q : (head_valid ? head[ADDR_W-1:0]  : '0);
    assign fetch_empty = !head_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_ptr_q <= RESET_PC;
            req_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            req_addr_q  <= req_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = fetch_ptr_q;
        req_addr_d  = req_addr_q;
        mem_req     = 1'b0;
        mem_addr    = '0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_ptr_d = redirect_pc;
                    state_d     = REQ;
                end else if (count < CW'(DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = fetch_ptr_q;
                if (mem_ack) begin
                    req_addr_d = fetch_ptr_q;
                    if (redirect) begin
                        fetch_ptr_d = redirect_pc;
                        state_d     = DROP;
                    end else begin
                        fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
                        state_d     = WAIT;
                    end
                end else if (redirect) begin
                    fetch_ptr_d = redirect_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_ptr_d = redirect_pc;
                    state_d     = mem_valid ? REQ : DROP;
                end else if (mem_valid) begin
                    state_d = (count_nxt < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirect) fetch_ptr_d = redirect_pc;
                if (mem_valid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: scripted and auto-responding memory,
// scoreboard queues of expected request addresses and presented instructions.
module tb_fetch_prefetch;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               redirect = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack, mem_valid;
    logic [INSTR_W-1:0] mem_data;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_take = 1'b0;
    logic               fetch_empty;

    logic               auto_mem = 1'b0, man_ack = 1'b0, man_valid = 1'b0;
    logic [INSTR_W-1:0] man_data = '0;
    logic               auto_valid;
    logic [INSTR_W-1:0] auto_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_prefetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(16'h0100)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_valid(mem_valid), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_take(instr_take), .fetch_empty(fetch_empty)
    );

    // Zero-wait memory: ack in the request cycle, data the cycle after; data = {C0DE, addr}.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_valid <= 1'b0;
            auto_data  <= '0;
        end else begin
            auto_valid <= auto_mem & mem_req;
            auto_data  <= {16'hC0DE, mem_addr};
        end
    end
    assign mem_ack   = auto_mem ? mem_req    : man_ack;
    assign mem_valid = auto_mem ? auto_valid : man_valid;
    assign mem_data  = auto_mem ? auto_data  : man_data;

    task automatic do_reset(input logic automem);
        rst = 1'b1; redirect = 1'b0; instr_take = 1'b0;
        man_ack = 1'b0; man_valid = 1'b0; man_data = '0;
        auto_mem = automem;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr_data !== 32'h0) begin n_err++; $display("FAIL reset_instr_data: got %h want 0", instr_data); end
        n_cmp++; if (instr_pc !== 16'h0) begin n_err++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        n_cmp++; if (fetch_empty !== 1'b1) begin n_err++; $display("FAIL reset_fetch_empty: got %b want 1", fetch_empty); end
    endtask

    task automatic test_stream();
        logic [ADDR_W-1:0] q_addr[$];
        logic [ADDR_W-1:0] q_pc[$];
        logic [ADDR_W-1:0] e;
        int first_v, n_pop;
        do_reset(1'b1);
        instr_take = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q_addr.push_back(16'h0100 + 16'(i));
            q_pc.push_back(16'h0100 + 16'(i));
        end
        first_v = -1; n_pop = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_req && mem_ack) begin
                e = q_addr.pop_front();
                n_cmp++; if (mem_addr !== e) begin n_err++; $display("FAIL stream_addr: got %h want %h", mem_addr, e); end
            end
            if (instr_valid) begin
                if (first_v < 0) first_v = c;
                e = q_pc.pop_front();
                n_pop++;
                n_cmp++; if (instr_pc !== e) begin n_err++; $display("FAIL stream_pc: got %h want %h", instr_pc, e); end
                n_cmp++; if (instr_data !== {16'hC0DE, e}) begin n_err++; $display("FAIL stream_data: got %h want %h", instr_data, {16'hC0DE, e}); end
            end
        end
        n_cmp++; if (first_v !== (BYP ? 2 : 3)) begin n_err++; $display("FAIL stream_latency: got %0d want %0d", first_v, BYP ? 2 : 3); end
        n_cmp++; if (n_pop !== (BYP ? 6 : 5)) begin n_err++; $display("FAIL stream_count: got %0d want %0d", n_pop, BYP ? 6 : 5); end
    endtask

    task automatic test_fill();
        logic [ADDR_W-1:0] q_pc[$];
        logic [ADDR_W-1:0] e;
        int acks, guard;
        do_reset(1'b1);
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req && mem_ack) acks++;
        end
        n_cmp++; if (acks !== DEPTH) begin n_err++; $display("FAIL fill_acks: got %0d want %0d", acks, DEPTH); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL fill_req_idle: got %b want 0", mem_req); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid: got %b want 1", instr_valid); end
        n_cmp++; if (fetch_empty !== 1'b0) begin n_err++; $display("FAIL fill_empty: got %b want 0", fetch_empty); end
        n_cmp++; if (instr_pc !== 16'h0100) begin n_err++; $display("FAIL fill_head: got %h want 0100", instr_pc); end
        instr_take = 1'b1;
        @(negedge clk);
        instr_take = 1'b0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req && mem_ack) acks++;
        end
        n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL fill_one_more: got %0d want 1", acks); end
        for (int i = 1; i <= 4; i++) q_pc.push_back(16'h0100 + 16'(i));
        instr_take = 1'b1;
        guard = 0;
        while (q_pc.size() != 0 && guard < 20) begin
            if (instr_valid) begin
                e = q_pc.pop_front();
                n_cmp++; if (instr_pc !== e) begin n_err++; $display("FAIL fill_drain: got %h want %h", instr_pc, e); end
            end
            @(negedge clk);
            guard++;
        end
        n_cmp++; if (q_pc.size() !== 0) begin n_err++; $display("FAIL fill_drain_timeout: got %0d left want 0", q_pc.size()); end
        instr_take = 1'b0;
    endtask

    task automatic test_redirect_wait();
        int guard;
        do_reset(1'b0);
        guard = 0;
        @(negedge clk);
        while (!mem_req && guard < 10) begin @(negedge clk); guard++; end
        n_cmp++; if (mem_addr !== 16'h0100) begin n_err++; $display("FAIL rw_first_addr: got %h want 0100", mem_addr); end
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0; man_valid = 1'b1; man_data = 32'hAAAA0100;
        @(negedge clk);
        man_valid = 1'b0;
        n_cmp++; if (instr_pc !== 16'h0100 || instr_valid !== 1'b1) begin n_err++; $display("FAIL rw_head: got %b/%h want 1/0100", instr_valid, instr_pc); end
        n_cmp++; if (mem_addr !== 16'h0101 || mem_req !== 1'b1) begin n_err++; $display("FAIL rw_second_req: got %b/%h want 1/0101", mem_req, mem_addr); end
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (fetch_empty !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_flush: got empty=%b valid=%b want 1/0", fetch_empty, instr_valid); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rw_drop_noreq: got %b want 0", mem_req); end
        man_valid = 1'b1; man_data = 32'hDEADBEEF;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_drop_present: got %b data %h want 0", instr_valid, instr_data); end
        @(negedge clk);
        man_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_discard: got valid=%b data=%h want 0", instr_valid, instr_data); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin n_err++; $display("FAIL rw_new_addr: got %b/%h want 1/0040", mem_req, mem_addr); end
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0; man_valid = 1'b1; man_data = 32'h40404040;
        @(negedge clk);
        man_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr_data !== 32'h40404040) begin
            n_err++; $display("FAIL rw_new_entry: got %b/%h/%h want 1/0040/40404040", instr_valid, instr_pc, instr_data); end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] q_addr[$];
        logic [ADDR_W-1:0] q_pc[$];
        logic [ADDR_W-1:0] e;
        int n_pop;
        do_reset(1'b1);
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        instr_take = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q_addr.push_back(16'hFFFF + 16'(i));
            q_pc.push_back(16'hFFFF + 16'(i));
        end
        n_pop = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            if (mem_req && mem_ack) begin
                e = q_addr.pop_front();
                n_cmp++; if (mem_addr !== e) begin n_err++; $display("FAIL wrap_addr: got %h want %h", mem_addr, e); end
            end
            if (instr_valid) begin
                e = q_pc.pop_front();
                n_pop++;
                n_cmp++; if (instr_pc !== e) begin n_err++; $display("FAIL wrap_pc: got %h want %h", instr_pc, e); end
            end
        end
        n_cmp++; if (n_pop < 3) begin n_err++; $display("FAIL wrap_count: got %0d want >=3", n_pop); end
    endtask

    task automatic test_redirect_take();
        logic [ADDR_W-1:0] q_pc[$];
        logic [ADDR_W-1:0] e;
        int n_pop;
        do_reset(1'b1);
        repeat (5) @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || fetch_empty !== 1'b0) begin
            n_err++; $display("FAIL rt_two_queued: got %b/%h/%b want 1/0100/0", instr_valid, instr_pc, fetch_empty); end
        redirect = 1'b1; redirect_pc = 16'h0200; instr_take = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (fetch_empty !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rt_flush: got empty=%b valid=%b want 1/0", fetch_empty, instr_valid); end
        for (int i = 0; i < 6; i++) q_pc.push_back(16'h0200 + 16'(i));
        n_pop = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                e = q_pc.pop_front();
                n_pop++;
                n_cmp++; if (instr_pc !== e) begin n_err++; $display("FAIL rt_pc: got %h want %h", instr_pc, e); end
            end
        end
        n_cmp++; if (n_pop < 2) begin n_err++; $display("FAIL rt_count: got %0d want >=2", n_pop); end
        instr_take = 1'b0;
    endtask

    task automatic test_bypass();
        do_reset(1'b0);
        instr_take = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin n_err++; $display("FAIL by_req: got %b/%h want 1/0100", mem_req, mem_addr); end
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0; man_valid = 1'b1; man_data = 32'h12345678;
        #1;
        n_cmp++; if (instr_valid !== BYP) begin n_err++; $display("FAIL by_same_cycle_valid: got %b want %b", instr_valid, BYP); end
        if (BYP) begin
            n_cmp++; if (instr_data !== 32'h12345678 || instr_pc !== 16'h0100) begin
                n_err++; $display("FAIL by_same_cycle_data: got %h/%h want 12345678/0100", instr_data, instr_pc); end
        end
        @(negedge clk);
        man_valid = 1'b0;
        n_cmp++; if (fetch_empty !== BYP) begin n_err++; $display("FAIL by_queue_empty: got %b want %b", fetch_empty, BYP); end
        n_cmp++; if (instr_valid !== !BYP) begin n_err++; $display("FAIL by_next_valid: got %b want %b", instr_valid, !BYP); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0101) begin n_err++; $display("FAIL by_next_req: got %b/%h want 1/0101", mem_req, mem_addr); end
        instr_take = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_redirect_wait();
        test_wrap();
        test_redirect_take();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
